// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RISC-V core.
// Sequences fetch/decode/execute over a shared ULA, register file and
// unified req/ready memory. All control outputs are decoded from the
// current state plus the instruction fields, Zero and MemReady; only
// the state, the retired-instruction counter and the trap flag are registered.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ULAControl,
  output logic             Branch,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstRet
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEMADR   = 4'h2,
    S_MEMREAD  = 4'h3,
    S_MEMWB    = 4'h4,
    S_MEMWRITE = 4'h5,
    S_EXECR    = 4'h6,
    S_EXECI    = 4'h7,
    S_ALUWB    = 4'h8,
    S_BEQ      = 4'h9,
    S_JALR1    = 4'hA,
    S_JALR2    = 4'hB,
    S_JALR3    = 4'hC,
    S_TRAP     = 4'hF
  } state_t;

  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_BEQ  = 7'h63;

  // R-type ULA operation from {funct3, funct7[5]}; unknown combos pass through.
  function automatic logic [2:0] alu_r(input logic [2:0] f3, input logic f75);
    logic [2:0] r;
    case ({f3, f75})
      4'b0000: r = 3'b000;
      4'b0001: r = 3'b001;
      4'b1110: r = 3'b010;
      4'b1100: r = 3'b011;
      4'b0100: r = 3'b101;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  // I-type ULA operation from funct3 alone (funct7 carries immediate bits).
  function automatic logic [2:0] alu_i(input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      3'b000:  r = 3'b000;
      3'b111:  r = 3'b010;
      3'b110:  r = 3'b011;
      3'b010:  r = 3'b101;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] instret_r;
  logic             illegal_r;
  logic             retire_s;

  logic       memreq_s;
  logic       memwrite_s;
  logic       adrsrc_s;
  logic       irwrite_s;
  logic       pcwrite_s;
  logic       regwrite_s;
  logic [1:0] resultsrc_s;
  logic [1:0] ulasrca_s;
  logic [1:0] ulasrcb_s;
  logic [1:0] immsrc_s;
  logic [2:0] ulacontrol_s;
  logic       branch_s;

  // Only funct7[5] selects an operation; the remaining bits are don't-care.
  logic unused_s;
  assign unused_s = ^{Funct7[6], Funct7[4:0]};

  // State, retirement counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      instret_r <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (retire_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state_nxt_s == S_TRAP) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Next-state selection; unreachable encodings fall into the trap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (MemReady) state_nxt_s = S_DECODE;
        else          state_nxt_s = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_R:         state_nxt_s = S_EXECR;
          OP_I:         state_nxt_s = S_EXECI;
          OP_JALR:      state_nxt_s = S_JALR1;
          OP_BEQ:       state_nxt_s = S_BEQ;
          default:      state_nxt_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_SW) state_nxt_s = S_MEMWRITE;
        else             state_nxt_s = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (MemReady) state_nxt_s = S_MEMWB;
        else          state_nxt_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (MemReady) state_nxt_s = S_FETCH;
        else          state_nxt_s = S_MEMWRITE;
      end
      S_MEMWB:  state_nxt_s = S_FETCH;
      S_EXECR:  state_nxt_s = S_ALUWB;
      S_EXECI:  state_nxt_s = S_ALUWB;
      S_ALUWB:  state_nxt_s = S_FETCH;
      S_BEQ:    state_nxt_s = S_FETCH;
      S_JALR1:  state_nxt_s = S_JALR2;
      S_JALR2:  state_nxt_s = S_JALR3;
      S_JALR3:  state_nxt_s = S_FETCH;
      S_TRAP:   state_nxt_s = S_TRAP;
      default:  state_nxt_s = S_TRAP;
    endcase
  end

  // Datapath control decode and retirement strobe for the current state.
  always_comb begin
    memreq_s     = 1'b0;
    memwrite_s   = 1'b0;
    adrsrc_s     = 1'b0;
    irwrite_s    = 1'b0;
    pcwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    resultsrc_s  = 2'b00;
    ulasrca_s    = 2'b00;
    ulasrcb_s    = 2'b00;
    immsrc_s     = 2'b00;
    ulacontrol_s = 3'b000;
    branch_s     = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        memreq_s = 1'b1;
        if (MemReady) begin
          irwrite_s   = 1'b1;
          pcwrite_s   = 1'b1;
          ulasrcb_s   = 2'b10;
          resultsrc_s = 2'b10;
        end else begin
          irwrite_s = 1'b0;
        end
      end
      S_DECODE: begin
        ulasrca_s = 2'b01;
        ulasrcb_s = 2'b01;
        if (Op == OP_BEQ)     immsrc_s = 2'b10;
        else if (Op == OP_SW) immsrc_s = 2'b01;
        else                  immsrc_s = 2'b00;
      end
      S_MEMADR: begin
        ulasrca_s = 2'b10;
        ulasrcb_s = 2'b01;
        if (Op == OP_SW) immsrc_s = 2'b01;
        else             immsrc_s = 2'b00;
      end
      S_MEMREAD: begin
        memreq_s = 1'b1;
        adrsrc_s = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = 1'b1;
        retire_s    = 1'b1;
      end
      S_MEMWRITE: begin
        memreq_s   = 1'b1;
        memwrite_s = 1'b1;
        adrsrc_s   = 1'b1;
        retire_s   = MemReady;
      end
      S_EXECR: begin
        ulasrca_s    = 2'b10;
        ulacontrol_s = alu_r(Funct3, Funct7[5]);
      end
      S_EXECI: begin
        ulasrca_s    = 2'b10;
        ulasrcb_s    = 2'b01;
        ulacontrol_s = alu_i(Funct3);
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_BEQ: begin
        ulasrca_s    = 2'b10;
        ulacontrol_s = 3'b001;
        branch_s     = 1'b1;
        pcwrite_s    = Zero;
        retire_s     = 1'b1;
      end
      S_JALR1: begin
        ulasrca_s = 2'b10;
        ulasrcb_s = 2'b01;
      end
      S_JALR2: begin
        pcwrite_s = 1'b1;
        ulasrca_s = 2'b01;
        ulasrcb_s = 2'b10;
      end
      S_JALR3: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  // While reset is held every control strobe is forced low so no write escapes.
  assign MemReq     = rst_n & memreq_s;
  assign MemWrite   = rst_n & memwrite_s;
  assign AdrSrc     = rst_n & adrsrc_s;
  assign IRWrite    = rst_n & irwrite_s;
  assign PCWrite    = rst_n & pcwrite_s;
  assign RegWrite   = rst_n & regwrite_s;
  assign ResultSrc  = rst_n ? resultsrc_s  : 2'b00;
  assign ULASrcA    = rst_n ? ulasrca_s    : 2'b00;
  assign ULASrcB    = rst_n ? ulasrcb_s    : 2'b00;
  assign ImmSrc     = rst_n ? immsrc_s     : 2'b00;
  assign ULAControl = rst_n ? ulacontrol_s : 3'b000;
  assign Branch     = rst_n & branch_s;
  assign Illegal    = rst_n & illegal_r;
  assign State      = state_r;
  assign InstRet    = instret_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed instruction table,
// randomized instruction stream against a trace-generating reference model,
// and hand-written reset / trap sequences.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             memready;
  logic             MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Branch, Illegal;
  logic [1:0]       ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0]       ULAControl;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstRet;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct3(funct3), .Funct7(funct7),
    .Zero(zero), .MemReady(memready), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ImmSrc(ImmSrc),
    .ULAControl(ULAControl), .Branch(Branch), .Illegal(Illegal), .State(State),
    .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [2:0] ula;
    logic       branch;
    logic       illegal;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    logic mr;
    logic z;
    ctl_t e;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    int         mw;
    int         cyc;
    logic [2:0] ula;
    logic [1:0] imm;
    int         req;
    int         pcw;
    int         rw;
  } tab_t;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_cnt;
  cyc_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t cur();
    ctl_t c;
    c.memreq = MemReq;   c.memwrite = MemWrite; c.adrsrc = AdrSrc;
    c.irwrite = IRWrite; c.pcwrite = PCWrite;   c.regwrite = RegWrite;
    c.resultsrc = ResultSrc; c.srca = ULASrcA;  c.srcb = ULASrcB;
    c.imm = ImmSrc; c.ula = ULAControl; c.branch = Branch;
    c.illegal = Illegal; c.st = State;
    return c;
  endfunction

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic cyc_t mk(input logic [3:0] st);
    cyc_t c;
    c.mr = 1'($urandom);
    c.z  = 1'($urandom);
    c.e  = blank(st);
    return c;
  endfunction

  // Arithmetic meaning of R-type / I-type encodings in the ULAControl code space.
  function automatic logic [2:0] ref_r(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'd0 && !f7[5]) return 3'b000;       // add
    else if (f3 == 3'd0 && f7[5]) return 3'b001;   // sub
    else if (f3 == 3'd7 && !f7[5]) return 3'b010;  // and
    else if (f3 == 3'd6 && !f7[5]) return 3'b011;  // or
    else if (f3 == 3'd2 && !f7[5]) return 3'b101;  // slt
    else return 3'b100;
  endfunction

  function automatic logic [2:0] ref_i(input logic [2:0] f3);
    if (f3 == 3'd0) return 3'b000;
    else if (f3 == 3'd7) return 3'b010;
    else if (f3 == 3'd6) return 3'b011;
    else if (f3 == 3'd2) return 3'b101;
    else return 3'b100;
  endfunction

  // Build the expected cycle-by-cycle trace of one instruction.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw);
    cyc_t c;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = mk(4'h0);
      c.mr = (i == fw);
      c.e.memreq = 1'b1;
      if (i == fw) begin
        c.e.irwrite = 1'b1; c.e.pcwrite = 1'b1;
        c.e.srcb = 2'b10;   c.e.resultsrc = 2'b10;
      end
      q.push_back(c);
    end
    c = mk(4'h1);
    c.e.srca = 2'b01; c.e.srcb = 2'b01;
    c.e.imm = (o == 7'h63) ? 2'b10 : (o == 7'h23) ? 2'b01 : 2'b00;
    q.push_back(c);
    if (o == 7'h03 || o == 7'h23) begin
      c = mk(4'h2);
      c.e.srca = 2'b10; c.e.srcb = 2'b01;
      c.e.imm = (o == 7'h23) ? 2'b01 : 2'b00;
      q.push_back(c);
      for (int i = 0; i <= mw; i++) begin
        c = mk((o == 7'h23) ? 4'h5 : 4'h3);
        c.mr = (i == mw);
        c.e.memreq = 1'b1; c.e.adrsrc = 1'b1; c.e.memwrite = (o == 7'h23);
        q.push_back(c);
      end
      if (o == 7'h03) begin
        c = mk(4'h4);
        c.e.resultsrc = 2'b01; c.e.regwrite = 1'b1;
        q.push_back(c);
      end
    end else if (o == 7'h33 || o == 7'h13) begin
      c = mk((o == 7'h33) ? 4'h6 : 4'h7);
      c.e.srca = 2'b10;
      c.e.srcb = (o == 7'h33) ? 2'b00 : 2'b01;
      c.e.ula  = (o == 7'h33) ? ref_r(f3, f7) : ref_i(f3);
      q.push_back(c);
      c = mk(4'h8);
      c.e.regwrite = 1'b1;
      q.push_back(c);
    end else if (o == 7'h63) begin
      c = mk(4'h9);
      c.e.srca = 2'b10; c.e.ula = 3'b001; c.e.branch = 1'b1; c.e.pcwrite = c.z;
      q.push_back(c);
    end else begin
      c = mk(4'hA);
      c.e.srca = 2'b10; c.e.srcb = 2'b01;
      q.push_back(c);
      c = mk(4'hB);
      c.e.pcwrite = 1'b1; c.e.srca = 2'b01; c.e.srcb = 2'b10;
      q.push_back(c);
      c = mk(4'hC);
      c.e.regwrite = 1'b1;
      q.push_back(c);
    end
  endtask

  // Apply one directed instruction and measure its observable behaviour.
  task automatic run_tab(input tab_t t, input int idx);
    int cyc = 0, wcnt = 0, reqc = 0, pcwc = 0, rwc = 0;
    logic [2:0] ula = 3'b111;
    logic [1:0] imm = 2'b11;
    logic done = 1'b0;
    op = t.op; funct3 = t.f3; funct7 = t.f7; zero = t.z;
    while (!done && cyc < 30) begin
      if (State == 4'h3 || State == 4'h5) begin
        memready = (wcnt == t.mw);
        wcnt++;
      end else begin
        memready = 1'b1;
      end
      @(negedge clk);
      reqc += int'(MemReq); pcwc += int'(PCWrite); rwc += int'(RegWrite);
      if (State == 4'h6 || State == 4'h7 || State == 4'h9) ula = ULAControl;
      if (State == 4'h1) imm = ImmSrc;
      @(posedge clk); #1;
      cyc++;
      if (State == 4'h0) done = 1'b1;
    end
    exp_cnt = exp_cnt + 1;
    chk($sformatf("tab%0d_cycles", idx), 64'(cyc), 64'(t.cyc));
    chk($sformatf("tab%0d_ula", idx), 64'(ula), 64'(t.ula));
    chk($sformatf("tab%0d_imm", idx), 64'(imm), 64'(t.imm));
    chk($sformatf("tab%0d_memreq_cycles", idx), 64'(reqc), 64'(t.req));
    chk($sformatf("tab%0d_pcwrite_count", idx), 64'(pcwc), 64'(t.pcw));
    chk($sformatf("tab%0d_regwrite_count", idx), 64'(rwc), 64'(t.rw));
    chk($sformatf("tab%0d_instret", idx), 64'(InstRet), 64'(exp_cnt));
  endtask

  tab_t tab[17];
  logic [6:0] ops[6];

  initial begin
    tab[0]  = '{7'h33, 3'd0, 7'h00, 1'b0, 0, 4, 3'b000, 2'b00, 1, 1, 1};
    tab[1]  = '{7'h33, 3'd0, 7'h20, 1'b0, 0, 4, 3'b001, 2'b00, 1, 1, 1};
    tab[2]  = '{7'h33, 3'd7, 7'h00, 1'b0, 0, 4, 3'b010, 2'b00, 1, 1, 1};
    tab[3]  = '{7'h33, 3'd6, 7'h00, 1'b0, 0, 4, 3'b011, 2'b00, 1, 1, 1};
    tab[4]  = '{7'h33, 3'd2, 7'h00, 1'b0, 0, 4, 3'b101, 2'b00, 1, 1, 1};
    tab[5]  = '{7'h33, 3'd4, 7'h00, 1'b0, 0, 4, 3'b100, 2'b00, 1, 1, 1};
    tab[6]  = '{7'h33, 3'd7, 7'h20, 1'b0, 0, 4, 3'b100, 2'b00, 1, 1, 1};
    tab[7]  = '{7'h13, 3'd0, 7'h20, 1'b0, 0, 4, 3'b000, 2'b00, 1, 1, 1};
    tab[8]  = '{7'h13, 3'd2, 7'h00, 1'b0, 0, 4, 3'b101, 2'b00, 1, 1, 1};
    tab[9]  = '{7'h13, 3'd7, 7'h00, 1'b0, 0, 4, 3'b010, 2'b00, 1, 1, 1};
    tab[10] = '{7'h13, 3'd6, 7'h00, 1'b0, 0, 4, 3'b011, 2'b00, 1, 1, 1};
    tab[11] = '{7'h13, 3'd4, 7'h00, 1'b0, 0, 4, 3'b100, 2'b00, 1, 1, 1};
    tab[12] = '{7'h03, 3'd2, 7'h00, 1'b0, 3, 8, 3'b111, 2'b00, 5, 1, 1};
    tab[13] = '{7'h23, 3'd2, 7'h00, 1'b0, 0, 4, 3'b111, 2'b01, 2, 1, 0};
    tab[14] = '{7'h63, 3'd0, 7'h00, 1'b1, 0, 3, 3'b001, 2'b10, 1, 2, 0};
    tab[15] = '{7'h63, 3'd0, 7'h00, 1'b0, 0, 3, 3'b001, 2'b10, 1, 1, 0};
    tab[16] = '{7'h67, 3'd0, 7'h00, 1'b0, 0, 5, 3'b111, 2'b00, 1, 2, 1};
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h67;

    // Reset from power-up: outputs low while held, FETCH request after release.
    rst_n = 1'b0; op = 7'h00; funct3 = 3'd0; funct7 = 7'h00; zero = 1'b0; memready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = '0;
    @(negedge clk);
    chk("reset_outputs", 64'(cur()), 64'(blank(4'h0)));
    chk("reset_instret", 64'(InstRet), 64'(exp_cnt));
    @(posedge clk); #1;
    rst_n = 1'b1; memready = 1'b0;
    @(negedge clk);
    begin
      ctl_t e = blank(4'h0);
      e.memreq = 1'b1;
      chk("fetch_after_reset", 64'(cur()), 64'(e));
    end
    @(posedge clk); #1;

    // Directed instruction table.
    for (int i = 0; i < 17; i++) run_tab(tab[i], i);

    // Randomized instruction stream against the trace model.
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 5)];
      funct3 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) funct7 = 7'($urandom);
      else funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      build(op, funct3, funct7, $urandom_range(0, 2), $urandom_range(0, 3));
      foreach (q[k]) begin
        memready = q[k].mr;
        zero = q[k].z;
        @(negedge clk);
        chk($sformatf("rand%0d_cyc%0d_ctl", n, k), 64'(cur()), 64'(q[k].e));
        chk($sformatf("rand%0d_cyc%0d_instret", n, k), 64'(InstRet), 64'(exp_cnt));
        @(posedge clk); #1;
      end
      exp_cnt = exp_cnt + 1;
    end
    chk("rand_final_instret", 64'(InstRet), 64'(exp_cnt));

    // Reset in the middle of a stalled load.
    op = 7'h03; funct3 = 3'd2; funct7 = 7'h00; memready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    memready = 1'b0;
    @(negedge clk);
    begin
      ctl_t e = blank(4'h3);
      e.memreq = 1'b1; e.adrsrc = 1'b1;
      chk("memread_stall", 64'(cur()), 64'(e));
    end
    rst_n = 1'b0;
    #1;
    chk("outputs_forced_low", 64'(cur()), 64'(blank(4'h3)));
    @(posedge clk); #1;
    exp_cnt = '0;
    chk("midload_reset_state", 64'(State), 64'(4'h0));
    chk("midload_reset_instret", 64'(InstRet), 64'(exp_cnt));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midload_fetch_req", 64'(MemReq), 64'(1'b1));
    @(posedge clk); #1;

    // Unknown opcode: trap, hold 100 cycles, clear by reset.
    op = 7'h7F; memready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 100; i++) begin
      ctl_t e = blank(4'hF);
      e.illegal = 1'b1;
      memready = 1'($urandom);
      zero = 1'($urandom);
      @(negedge clk);
      chk($sformatf("trap%0d_ctl", i), 64'(cur()), 64'(e));
      chk($sformatf("trap%0d_instret", i), 64'(InstRet), 64'(exp_cnt));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; memready = 1'b0;
    @(negedge clk);
    begin
      ctl_t e = blank(4'h0);
      e.memreq = 1'b1;
      chk("trap_cleared", 64'(cur()), 64'(e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
